spi_reg_port: RTL

SPI_REG_PORT -- requirements
Module: spi_reg_port

---
 rtl/spi_reg_port_pkg.sv | 21 ++
 rtl/spi_reg_port_sync.sv | 32 +++
 rtl/spi_reg_port.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_port_pkg.sv
// Shared types and constants for the SPI register port: FSM states, R/W bit rule, reset values.
package spi_reg_port_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StWrite,
    StRead
  } state_e;

  // Synchronizer reset values match an idle, deselected bus.
  localparam logic SclkRstVal = 1'b0;
  localparam logic CsNRstVal  = 1'b1;
  localparam logic MosiRstVal = 1'b0;

  // The command word's MSB selects read (1) or write (0).
  function automatic int unsigned rw_bit_pos(input int unsigned data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/spi_reg_port_sync.sv
// Two-flop synchronizer with a third stage used for registered rise/fall detection.
module spi_reg_port_sync #(
  parameter logic RstVal = 1'b0
) (
  input  logic iclk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;
  logic       rise_q, fall_q;

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      sync_q <= {3{RstVal}};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], din_i};
      rise_q <= sync_q[1] & ~sync_q[2];
      fall_q <= ~sync_q[1] & sync_q[2];
    end
  end

  assign dout_o = sync_q[1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_reg_port.sv
// SPI mode-0 slave bridging serial words to a register-file write strobe and read mux.
// Optional sclk inactivity timeout is enabled by defining SPI_REG_PORT_TIMEOUT_EN.
module spi_reg_port
  import spi_reg_port_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned TIMEOUT_CYC = 7
) (
  input  logic              iclk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned     CntW    = $clog2(DATA_W);
  localparam int unsigned     RwPos   = rw_bit_pos(DATA_W);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_reg_port_sync #(.RstVal(SclkRstVal)) u_sync_sclk (
    .iclk  (iclk),
    .rst   (rst),
    .din_i (sclk),
    .dout_o(sclk_lvl),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  spi_reg_port_sync #(.RstVal(CsNRstVal)) u_sync_cs_n (
    .iclk  (iclk),
    .rst   (rst),
    .din_i (cs_n),
    .dout_o(cs_s),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  spi_reg_port_sync #(.RstVal(MosiRstVal)) u_sync_mosi (
    .iclk  (iclk),
    .rst   (rst),
    .din_i (mosi),
    .dout_o(mosi_s),
    .rise_o(mosi_rise),
    .fall_o(mosi_fall)
  );

  assign unused_edges = ^{sclk_lvl, cs_rise, cs_fall, mosi_rise, mosi_fall};

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              done_q, load_q, load_d, wr_en_q, wr_en_d, ferr_q, ferr_d;
  logic              take_bit, complete, timeout;

  assign take_bit = sclk_rise & ((state_q != StIdle) | ~cs_s);
  assign complete = take_bit & (cnt_q == LastBit);

`ifdef SPI_REG_PORT_TIMEOUT_EN
  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT_CYC);

  logic [15:0] idle_q, idle_d;
  logic        sclk_edge;

  assign sclk_edge = sclk_rise | sclk_fall;

  // Saturates so a stalled partial word aborts only once.
  always_comb begin
    idle_d = idle_q;
    if (sclk_edge || cs_s) begin
      idle_d = '0;
    end else if (idle_q != TimeoutCnt) begin
      idle_d = idle_q + 16'd1;
    end
  end

  assign timeout = ~sclk_edge & ~cs_s & (idle_q == TimeoutCnt - 16'd1) & (cnt_q != '0);

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = TIMEOUT_CYC[0];
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    out_d     = out_q;
    ptr_d     = ptr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    load_d    = 1'b0;
    wr_en_d   = 1'b0;
    ferr_d    = 1'b0;

    if (take_bit) begin
      shreg_d = {shreg_q[DATA_W-2:0], mosi_s};
      cnt_d   = complete ? '0 : cnt_q + 1'b1;
    end

    // The fall right after a word's last rise is not a shift, so a freshly loaded MSB survives.
    if (load_q) begin
      out_d = rd_data;
    end else if (sclk_fall && state_q == StRead && cnt_q != '0) begin
      out_d = {out_q[DATA_W-2:0], 1'b0};
    end

    unique case (state_q)
      StIdle: begin
        if (!cs_s) state_d = StAddr;
      end
      StAddr: begin
        if (done_q) begin
          ptr_d = shreg_q[ADDR_W-1:0];
          if (shreg_q[RwPos]) begin
            state_d = StRead;
            load_d  = 1'b1;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (done_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = shreg_q;
          ptr_d     = ptr_q + 1'b1;
        end
      end
      StRead: begin
        if (done_q) begin
          ptr_d  = ptr_q + 1'b1;
          load_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      cnt_d  = '0;
      ferr_d = 1'b1;
    end

    // A word completing as cs_n rises is still finished next cycle before going idle.
    if (cs_s && !complete) begin
      cnt_d = '0;
      if (state_q != StIdle) begin
        state_d = StIdle;
        ferr_d  = (cnt_q != '0);
      end
    end
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      out_q     <= '0;
      ptr_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      load_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      out_q     <= out_d;
      ptr_q     <= ptr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= complete;
      load_q    <= load_d;
      wr_en_q   <= wr_en_d;
      ferr_q    <= ferr_d;
    end
  end

  assign miso      = (state_q == StRead) & out_q[DATA_W-1];
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = ptr_q;
  assign busy      = (state_q != StIdle);
  assign frame_err = ferr_q;

endmodule
